onehot_encoder_rr: RTL and testbench

Parametrised, registered N-to-log2(N) encoder with a valid/ready handshake on both sides. It is the successor to the fixed 8-to-3 combinational encoder. Multi-hot request vectors are resolved by a rotating (round-robin) priority pointer instead of producing an undefined code. It sits between request-collecting logic (interrupt lines, channel requests) and any consumer that needs a binary index, one index per handshake.

---
 rtl/onehot_encoder_rr_if.sv | 32 +++
 rtl/onehot_encoder_rr.sv | 79 +++++++
 tb/tb_onehot_encoder_rr.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_encoder_rr_if.sv
// Request/index handshake bundle for onehot_encoder_rr.
// slave is the encoder's view; master is the requester/consumer view.
interface onehot_encoder_rr_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned W = $clog2(N);

    logic         in_valid;
    logic [N-1:0] inn;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out;
    logic         out_ready;

    modport slave (
        input  in_valid,
        input  inn,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out
    );

    modport master (
        output in_valid,
        output inn,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out
    );
endinterface

// File: rtl/onehot_encoder_rr.sv
// Registered N-to-log2(N) encoder with round-robin resolution of multi-hot requests.
// Optional sticky multi-hot flag (multi_err) when MULTI_HOT_ERR_EN is defined.
module onehot_encoder_rr #(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    onehot_encoder_rr_if.slave   bus
`ifdef MULTI_HOT_ERR_EN
    ,
    output logic                 multi_err
`endif
);
    localparam int unsigned W  = $clog2(N);
    localparam int unsigned WE = W + 1;

    logic [W-1:0]  ptr;
    logic [W-1:0]  grant_c;
    logic [W-1:0]  next_ptr_c;
    logic [WE-1:0] scan_idx_c;
    logic          any_c;
    logic          accept_c;

    // No skid buffer: a held output blocks the input side.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept_c     = bus.in_valid && bus.in_ready;

    // First set bit at or above ptr, wrapping at N (not 2^W).
    always_comb begin
        grant_c    = '0;
        any_c      = 1'b0;
        scan_idx_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx_c = WE'({1'b0, ptr}) + WE'(k);
            if (scan_idx_c >= WE'(N)) begin
                scan_idx_c = scan_idx_c - WE'(N);
            end
            if (!any_c && bus.inn[scan_idx_c[W-1:0]]) begin
                any_c   = 1'b1;
                grant_c = scan_idx_c[W-1:0];
            end
        end
    end

    assign next_ptr_c = (grant_c == W'(N - 1)) ? '0 : grant_c + W'(1);

    // Output register and priority pointer; zero vectors are consumed silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            ptr           <= '0;
        end else if (accept_c && any_c) begin
            bus.out_valid <= 1'b1;
            bus.out       <= grant_c;
            ptr           <= next_ptr_c;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef MULTI_HOT_ERR_EN
    logic multi_hot_c;

    // Two or more bits set iff clearing the lowest set bit leaves something.
    assign multi_hot_c = |(bus.inn & (bus.inn - N'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            multi_err <= 1'b0;
        end else if (accept_c && multi_hot_c) begin
            multi_err <= 1'b1;
        end
    end
`else
    // Multi-hot requests resolve silently; no detection logic is built.
`endif

endmodule

// File: tb/tb_onehot_encoder_rr.sv
// Directed self-checking bench for onehot_encoder_rr (N=8 and N=5 instances).
module tb_onehot_encoder_rr;
    logic clk = 1'b0;
    logic rst;

    int compared   = 0;
    int mismatched = 0;

    onehot_encoder_rr_if #(.N(8)) bus8 ();
    onehot_encoder_rr_if #(.N(5)) bus5 ();

`ifdef MULTI_HOT_ERR_EN
    logic merr8;
    logic merr5;
`endif

    onehot_encoder_rr #(.N(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
`ifdef MULTI_HOT_ERR_EN
        ,
        .multi_err (merr8)
`endif
    );

    onehot_encoder_rr #(.N(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
`ifdef MULTI_HOT_ERR_EN
        ,
        .multi_err (merr5)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.inn       = '0;
        bus8.out_ready = 1'b0;
        bus5.in_valid  = 1'b0;
        bus5.inn       = '0;
        bus5.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        compared++;
        if (bus8.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", bus8.out_valid); end
        compared++;
        if (bus8.out !== 3'd0) begin mismatched++; $display("FAIL reset_out: got %0d want 0", bus8.out); end
        compared++;
        if (dut8.ptr !== 3'd0) begin mismatched++; $display("FAIL reset_ptr: got %0d want 0", dut8.ptr); end
        compared++;
        if (bus8.in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", bus8.in_ready); end
        compared++;
        if (dut5.ptr !== 3'd0) begin mismatched++; $display("FAIL reset_ptr_n5: got %0d want 0", dut5.ptr); end
    endtask

    // Back-to-back single-hot sweep: one index per cycle, out_valid stays high.
    task automatic test_single_hot();
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus8.in_valid = 1'b1;
            bus8.inn      = 8'b1 << i;
            tick();
            compared++;
            if (bus8.out_valid !== 1'b1) begin mismatched++; $display("FAIL single_hot_valid[%0d]: got %b want 1", i, bus8.out_valid); end
            compared++;
            if (bus8.out !== 3'(i)) begin mismatched++; $display("FAIL single_hot_out[%0d]: got %0d want %0d", i, bus8.out, i); end
        end
        bus8.in_valid = 1'b0;
        bus8.inn      = '0;
        tick();
        compared++;
        if (bus8.out_valid !== 1'b0) begin mismatched++; $display("FAIL single_hot_drain: got %b want 0", bus8.out_valid); end
        compared++;
        if (dut8.ptr !== 3'd0) begin mismatched++; $display("FAIL single_hot_ptr_wrap: got %0d want 0", dut8.ptr); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_out [4];
        logic [2:0] exp_ptr [4];
        exp_out = '{3'd0, 3'd2, 3'd7, 3'd0};
        exp_ptr = '{3'd1, 3'd3, 3'd0, 3'd1};
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        bus8.inn       = 8'b1000_0101;
        for (int k = 0; k < 4; k++) begin
            tick();
            compared++;
            if (bus8.out !== exp_out[k]) begin mismatched++; $display("FAIL rr_out[%0d]: got %0d want %0d", k, bus8.out, exp_out[k]); end
            compared++;
            if (dut8.ptr !== exp_ptr[k]) begin mismatched++; $display("FAIL rr_ptr[%0d]: got %0d want %0d", k, dut8.ptr, exp_ptr[k]); end
        end
        bus8.in_valid = 1'b0;
        bus8.inn      = '0;
        tick();
    endtask

    task automatic test_backpressure();
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.inn       = 8'h08;
        tick();
        compared++;
        if (bus8.out !== 3'd3 || bus8.out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_first: got out=%0d v=%b want out=3 v=1", bus8.out, bus8.out_valid); end
        bus8.inn = 8'h40;
        for (int c = 0; c < 5; c++) begin
            compared++;
            if (bus8.in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, bus8.in_ready); end
            tick();
            compared++;
            if (bus8.out !== 3'd3 || bus8.out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_hold[%0d]: got out=%0d v=%b want out=3 v=1", c, bus8.out, bus8.out_valid); end
            compared++;
            if (dut8.ptr !== 3'd4) begin mismatched++; $display("FAIL bp_ptr[%0d]: got %0d want 4", c, dut8.ptr); end
        end
        bus8.out_ready = 1'b1;
        #1;
        compared++;
        if (bus8.in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready: got %b want 1", bus8.in_ready); end
        tick();
        compared++;
        if (bus8.out !== 3'd6 || bus8.out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_release: got out=%0d v=%b want out=6 v=1", bus8.out, bus8.out_valid); end
        compared++;
        if (dut8.ptr !== 3'd7) begin mismatched++; $display("FAIL bp_release_ptr: got %0d want 7", dut8.ptr); end
        bus8.in_valid = 1'b0;
        bus8.inn      = '0;
        tick();
        compared++;
        if (bus8.out_valid !== 1'b0 || bus8.out !== 3'd6) begin mismatched++; $display("FAIL bp_idle_keep: got out=%0d v=%b want out=6 v=0", bus8.out, bus8.out_valid); end
    endtask

    task automatic test_zero_vector();
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        bus8.inn       = '0;
        #1;
        compared++;
        if (bus8.in_ready !== 1'b1) begin mismatched++; $display("FAIL zero_in_ready: got %b want 1", bus8.in_ready); end
        tick();
        compared++;
        if (bus8.out_valid !== 1'b0 || bus8.out !== 3'd6) begin mismatched++; $display("FAIL zero_no_output: got out=%0d v=%b want out=6 v=0", bus8.out, bus8.out_valid); end
        compared++;
        if (dut8.ptr !== 3'd7) begin mismatched++; $display("FAIL zero_ptr: got %0d want 7", dut8.ptr); end
        // Grant line 1 (ptr 7 wraps), then a zero vector must drop out_valid.
        bus8.inn = 8'h02;
        tick();
        compared++;
        if (bus8.out !== 3'd1 || bus8.out_valid !== 1'b1) begin mismatched++; $display("FAIL zero_pre_grant: got out=%0d v=%b want out=1 v=1", bus8.out, bus8.out_valid); end
        bus8.inn = '0;
        tick();
        compared++;
        if (bus8.out_valid !== 1'b0 || bus8.out !== 3'd1) begin mismatched++; $display("FAIL zero_after_grant: got out=%0d v=%b want out=1 v=0", bus8.out, bus8.out_valid); end
        compared++;
        if (dut8.ptr !== 3'd2) begin mismatched++; $display("FAIL zero_after_ptr: got %0d want 2", dut8.ptr); end
        bus8.in_valid = 1'b0;
        tick();
    endtask

`ifdef MULTI_HOT_ERR_EN
    task automatic test_multi_err();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++;
        if (merr8 !== 1'b0) begin mismatched++; $display("FAIL merr_reset: got %b want 0", merr8); end
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        bus8.inn       = 8'h10;
        tick();
        compared++;
        if (merr8 !== 1'b0) begin mismatched++; $display("FAIL merr_single: got %b want 0", merr8); end
        bus8.inn = 8'h03;
        tick();
        compared++;
        if (merr8 !== 1'b1) begin mismatched++; $display("FAIL merr_set: got %b want 1", merr8); end
        compared++;
        if (bus8.out !== 3'd0) begin mismatched++; $display("FAIL merr_grant: got %0d want 0", bus8.out); end
        bus8.in_valid = 1'b0;
        bus8.inn      = '0;
        tick();
        tick();
        compared++;
        if (merr8 !== 1'b1) begin mismatched++; $display("FAIL merr_sticky: got %b want 1", merr8); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++;
        if (merr8 !== 1'b0) begin mismatched++; $display("FAIL merr_clear: got %b want 0", merr8); end
    endtask
`endif

    task automatic test_reset_mid();
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.inn       = 8'h20;
        tick();
        compared++;
        if (bus8.out !== 3'd5 || bus8.out_valid !== 1'b1) begin mismatched++; $display("FAIL rmid_pre: got out=%0d v=%b want out=5 v=1", bus8.out, bus8.out_valid); end
        bus8.in_valid = 1'b0;
        rst           = 1'b1;
        tick();
        rst = 1'b0;
        compared++;
        if (bus8.out_valid !== 1'b0 || bus8.out !== 3'd0) begin mismatched++; $display("FAIL rmid_drop: got out=%0d v=%b want out=0 v=0", bus8.out, bus8.out_valid); end
        compared++;
        if (dut8.ptr !== 3'd0) begin mismatched++; $display("FAIL rmid_ptr: got %0d want 0", dut8.ptr); end
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        bus8.inn       = 8'hFF;
        tick();
        compared++;
        if (bus8.out !== 3'd0 || bus8.out_valid !== 1'b1) begin mismatched++; $display("FAIL rmid_all: got out=%0d v=%b want out=0 v=1", bus8.out, bus8.out_valid); end
        compared++;
        if (dut8.ptr !== 3'd1) begin mismatched++; $display("FAIL rmid_all_ptr: got %0d want 1", dut8.ptr); end
        bus8.in_valid = 1'b0;
        bus8.inn      = '0;
        tick();
    endtask

    // N=5: pointer must wrap at 5, not at 8.
    task automatic test_wrap_n5();
        logic [2:0] exp_out [3];
        logic [2:0] exp_ptr [3];
        exp_out = '{3'd0, 3'd4, 3'd0};
        exp_ptr = '{3'd1, 3'd0, 3'd1};
        bus5.out_ready = 1'b1;
        bus5.in_valid  = 1'b1;
        bus5.inn       = 5'b10001;
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if (bus5.out !== exp_out[k] || bus5.out_valid !== 1'b1) begin mismatched++; $display("FAIL n5_out[%0d]: got out=%0d v=%b want out=%0d v=1", k, bus5.out, bus5.out_valid, exp_out[k]); end
            compared++;
            if (dut5.ptr !== exp_ptr[k]) begin mismatched++; $display("FAIL n5_ptr[%0d]: got %0d want %0d", k, dut5.ptr, exp_ptr[k]); end
        end
        bus5.in_valid = 1'b0;
        bus5.inn      = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_hot();
        test_round_robin();
        test_backpressure();
        test_zero_vector();
`ifdef MULTI_HOT_ERR_EN
        test_multi_err();
`endif
        test_reset_mid();
        test_wrap_n5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
